// File: rtl/monitor_pkg.sv
// Shared constants for the monitor tint pipeline: rendering modes and luma weights.
package monitor_pkg;

    // Rendering modes selectable through mode_req / reported on mode_active.
    typedef enum logic [1:0] {
        MODE_COLOUR = 2'd0,
        MODE_GREEN  = 2'd1,
        MODE_AMBER  = 2'd2,
        MODE_GREY   = 2'd3
    } mode_t;

    // Luma weights. They sum to 2^LUMA_SHIFT, so (WR*R + WG*G + WB*B) >> LUMA_SHIFT
    // never exceeds the channel maximum and needs no saturation.
    localparam int WR         = 5;
    localparam int WG         = 9;
    localparam int WB         = 2;
    localparam int LUMA_SHIFT = 4;

endpackage

// File: rtl/tint_luma.sv
// Stage-1 weighted luma sum S = WR*R + WG*G + WB*B, registered.
module tint_luma
    import monitor_pkg::*;
#(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [CW-1:0] r,
    input  logic [CW-1:0] g,
    input  logic [CW-1:0] b,
    output logic [CW+4:0] sum
);

    // Five extra bits hold 16*(2^CW-1) without overflow.
    localparam int SW = CW + 5;

    logic [SW-1:0] sum_c;

    // Weighted sum computed at full sum width.
    always_comb begin
        sum_c = SW'(WR) * SW'(r) + SW'(WG) * SW'(g) + SW'(WB) * SW'(b);
    end

    // Register the sum alongside the other stage-1 registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum <= '0;
        end else begin
            sum <= sum_c;
        end
    end

endmodule

// File: rtl/monitor_tint_pipe.sv
// Two-stage RGB to monitor rendering pipeline (colour/green/amber/grey) with
// delayed syncs and frame-boundary mode switching.
module monitor_tint_pipe
    import monitor_pkg::*;
#(
    parameter int CW          = 3,
    parameter int SYNC_SWITCH = 1,
    parameter int MODE_RST    = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [CW-1:0] ri,
    input  logic [CW-1:0] gi,
    input  logic [CW-1:0] bi,
    input  logic          hsync_n_i,
    input  logic          vsync_n_i,
    input  logic [1:0]    mode_req,
    output logic [CW-1:0] ro,
    output logic [CW-1:0] go,
    output logic [CW-1:0] bo,
    output logic          hsync_n_o,
    output logic          vsync_n_o,
    output logic [1:0]    mode_active
);

    localparam logic [1:0] MODE_RST_V = 2'(MODE_RST);

    // Stage-1 registers
    logic [CW-1:0] r1, g1, b1;
    logic          hs1, vs1;
    logic [CW+4:0] s1;

    // Frame-boundary detection
    logic v_prev;

    // Stage-2 combinational mapping
    logic [CW-1:0] y;
    logic [CW+1:0] y3;
    logic [CW-1:0] ro_c, go_c, bo_c;

    tint_luma #(.CW(CW)) u_luma (
        .clk     (clk),
        .reset_n (reset_n),
        .r       (ri),
        .g       (gi),
        .b       (bi),
        .sum     (s1)
    );

    // Stage 1: raw colour and syncs travel alongside the luma sum.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r1  <= '0;
            g1  <= '0;
            b1  <= '0;
            hs1 <= 1'b1;
            vs1 <= 1'b1;
        end else begin
            r1  <= ri;
            g1  <= gi;
            b1  <= bi;
            hs1 <= hsync_n_i;
            vs1 <= vsync_n_i;
        end
    end

    // Mode control: switch at the vsync falling edge, or every cycle when unsynchronised.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_prev      <= 1'b1;
            mode_active <= MODE_RST_V;
        end else begin
            v_prev <= vsync_n_i;
            if (SYNC_SWITCH != 0) begin
                if (v_prev && !vsync_n_i) begin
                    mode_active <= mode_req;
                end
            end else begin
                mode_active <= mode_req;
            end
        end
    end

    // Luma and per-mode tint mapping; the weight total makes Y fit CW bits.
    always_comb begin
        y    = CW'(s1 >> LUMA_SHIFT);
        y3   = (CW + 2)'(y) * (CW + 2)'(3);
        ro_c = r1;
        go_c = g1;
        bo_c = b1;
        case (mode_t'(mode_active))
            MODE_GREEN: begin
                ro_c = y >> 2;
                go_c = y;
                bo_c = y >> 3;
            end
            MODE_AMBER: begin
                ro_c = y;
                go_c = CW'(y3 >> 2);
                bo_c = '0;
            end
            MODE_GREY: begin
                ro_c = y;
                go_c = y;
                bo_c = y;
            end
            default: begin
                ro_c = r1;
                go_c = g1;
                bo_c = b1;
            end
        endcase
    end

    // Stage 2: registered outputs and delayed syncs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ro        <= '0;
            go        <= '0;
            bo        <= '0;
            hsync_n_o <= 1'b1;
            vsync_n_o <= 1'b1;
        end else begin
            ro        <= ro_c;
            go        <= go_c;
            bo        <= bo_c;
            hsync_n_o <= hs1;
            vsync_n_o <= vs1;
        end
    end

endmodule

// File: tb/tb_monitor_tint_pipe.sv
// Bench for monitor_tint_pipe: a frame-synchronised instance (MODE_RST=1) and an
// immediate-switch instance (MODE_RST=0) share one stimulus stream.
module tb_monitor_tint_pipe;

    localparam int CW = 3;
    localparam int W  = 6 * CW + 4;

    typedef struct {
        logic [1:0]    mode;
        logic [CW-1:0] r, g, b;
        logic [CW-1:0] er, eg, eb;
    } vec_t;

    // Clock / reset
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    logic [CW-1:0] ri = '0, gi = '0, bi = '0;
    logic          hsync_n_i = 1'b1, vsync_n_i = 1'b1;
    logic [1:0]    mode_req = 2'd0;

    logic [CW-1:0] ro, go, bo, ro2, go2, bo2;
    logic          hs_o, vs_o, hs_o2, vs_o2;
    logic [1:0]    mact, mact2;

    monitor_tint_pipe #(.CW(CW), .SYNC_SWITCH(1), .MODE_RST(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .ri(ri), .gi(gi), .bi(bi),
        .hsync_n_i(hsync_n_i), .vsync_n_i(vsync_n_i), .mode_req(mode_req),
        .ro(ro), .go(go), .bo(bo), .hsync_n_o(hs_o), .vsync_n_o(vs_o),
        .mode_active(mact)
    );

    monitor_tint_pipe #(.CW(CW), .SYNC_SWITCH(0), .MODE_RST(0)) u_imm (
        .clk(clk), .reset_n(reset_n), .ri(ri), .gi(gi), .bi(bi),
        .hsync_n_i(hsync_n_i), .vsync_n_i(vsync_n_i), .mode_req(mode_req),
        .ro(ro2), .go(go2), .bo(bo2), .hsync_n_o(hs_o2), .vsync_n_o(vs_o2),
        .mode_active(mact2)
    );

    // Scoreboard: {main rgb, hs, vs, imm rgb, hs, vs} per driven pixel.
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    logic [1:0] mact_m   = 2'd1;
    logic       v_prev_m = 1'b1;
    logic [1:0] imm_exp  = 2'd0;
    vec_t tab[10];

    // Reference rendering from the luma definition.
    function automatic logic [3*CW-1:0] model(input logic [1:0] m, input logic [CW-1:0] r, g, b);
        int s, y;
        s = 5 * int'(r) + 9 * int'(g) + 2 * int'(b);
        y = s / 16;
        case (m)
            2'd0:    return {r, g, b};
            2'd1:    return {CW'(y / 4), CW'(y), CW'(y / 8)};
            2'd2:    return {CW'(y), CW'((3 * y) / 4), CW'(0)};
            default: return {CW'(y), CW'(y), CW'(y)};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: check what is due, drive new inputs, push expectations.
    task automatic step(input logic [CW-1:0] r, g, b, input logic hs, vs,
                        input logic [1:0] mreq, input logic use_tab, input logic [3*CW-1:0] tab_rgb);
        logic [W-1:0] e;
        logic [3*CW-1:0] main_rgb;
        @(posedge clk);
        #1;
        check("mode_active", 32'(mact), 32'(mact_m));
        check("imm_mode_active", 32'(mact2), 32'(imm_exp));
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            check("pixel_sync", 32'({ro, go, bo, hs_o, vs_o, ro2, go2, bo2, hs_o2, vs_o2}), 32'(e));
        end
        ri = r; gi = g; bi = b;
        hsync_n_i = hs; vsync_n_i = vs; mode_req = mreq;
        if (v_prev_m && !vs) mact_m = mreq;
        v_prev_m = vs;
        imm_exp  = mreq;
        main_rgb = use_tab ? tab_rgb : model(mact_m, r, g, b);
        exp_q.push_back({main_rgb, hs, vs, model(mreq, r, g, b), hs, vs});
    endtask

    task automatic idle(input logic vs, input logic [1:0] mreq);
        step('0, '0, '0, 1'b1, vs, mreq, 1'b0, '0);
    endtask

    task automatic rand_step(input logic hs, vs, input logic [1:0] mreq);
        step(CW'($urandom_range(0, 7)), CW'($urandom_range(0, 7)), CW'($urandom_range(0, 7)),
             hs, vs, mreq, 1'b0, '0);
    endtask

    task automatic set_mode(input logic [1:0] m);
        idle(1'b1, m);
        repeat (4) idle(1'b0, m);
        repeat (2) idle(1'b1, m);
    endtask

    // Asynchronous reset assertion mid-cycle, then release and refill.
    task automatic do_reset();
        @(posedge clk);
        #1;
        ri = '0; gi = '0; bi = '0;
        hsync_n_i = 1'b1; vsync_n_i = 1'b1;
        reset_n = 1'b0;
        #1;
        check("rst_pixel", 32'({ro, go, bo, hs_o, vs_o}), 32'({9'd0, 2'b11}));
        check("rst_mode", 32'(mact), 32'd1);
        check("rst_imm", 32'({ro2, go2, bo2, hs_o2, vs_o2, mact2}), 32'({9'd0, 2'b11, 2'd0}));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
        repeat (2) exp_q.push_back({9'd0, 2'b11, 9'd0, 2'b11});
        mact_m   = 2'd1;
        v_prev_m = 1'b1;
        imm_exp  = mode_req;
    endtask

    initial begin
        tab[0] = '{2'd3, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
        tab[1] = '{2'd3, 3'd7, 3'd0, 3'd0, 3'd2, 3'd2, 3'd2};
        tab[2] = '{2'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        tab[3] = '{2'd1, 3'd0, 3'd7, 3'd0, 3'd0, 3'd3, 3'd0};
        tab[4] = '{2'd1, 3'd7, 3'd7, 3'd7, 3'd1, 3'd7, 3'd0};
        tab[5] = '{2'd1, 3'd3, 3'd4, 3'd5, 3'd0, 3'd3, 3'd0};
        tab[6] = '{2'd2, 3'd7, 3'd7, 3'd7, 3'd7, 3'd5, 3'd0};
        tab[7] = '{2'd2, 3'd4, 3'd2, 3'd1, 3'd2, 3'd1, 3'd0};
        tab[8] = '{2'd0, 3'd5, 3'd2, 3'd6, 3'd5, 3'd2, 3'd6};
        tab[9] = '{2'd0, 3'd7, 3'd0, 3'd3, 3'd7, 3'd0, 3'd3};

        do_reset();

        // Table vectors, consecutive pixels within each mode group.
        for (int i = 0; i < 10; i++) begin
            if (tab[i].mode != mact_m) set_mode(tab[i].mode);
            step(tab[i].r, tab[i].g, tab[i].b, 1'b1, 1'b1, tab[i].mode, 1'b1,
                 {tab[i].er, tab[i].eg, tab[i].eb});
        end

        // mode_req mid-line is ignored; 4-cycle hsync pulse must stay aligned.
        for (int i = 0; i < 8; i++) rand_step(!(i >= 2 && i < 6), 1'b1, 2'd3);
        idle(1'b0, 2'd3);
        repeat (3) idle(1'b0, 2'd3);
        idle(1'b1, 2'd3);
        idle(1'b1, 2'd1);
        idle(1'b1, 2'd3);
        repeat (2) rand_step(1'b1, 1'b1, 2'd3);

        // mode_req present only on the edge cycle is the one taken.
        idle(1'b1, 2'd0);
        idle(1'b0, 2'd2);
        idle(1'b0, 2'd0);
        idle(1'b1, 2'd0);
        repeat (3) rand_step(1'b1, 1'b1, 2'd0);

        // vsync stuck low: a single edge, then mode holds.
        idle(1'b0, 2'd1);
        for (int i = 0; i < 10; i++) rand_step(1'b1, 1'b0, 2'($urandom_range(0, 3)));
        idle(1'b1, 2'd0);

        // Random traffic with occasional vsync edges.
        for (int i = 0; i < 60; i++)
            rand_step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)));

        // Reset mid-frame with non-zero pixels in flight.
        rand_step(1'b0, 1'b1, 2'd2);
        rand_step(1'b1, 1'b1, 2'd2);
        mode_req = 2'd3;
        do_reset();
        for (int i = 0; i < 6; i++) rand_step(1'b1, 1'b1, 2'd3);
        idle(1'b0, 2'd3);
        for (int i = 0; i < 4; i++) rand_step(1'b1, 1'b0, 2'd3);
        for (int i = 0; i < 4; i++) rand_step(1'b1, 1'b1, 2'd0);
        idle(1'b1, 2'd0);
        idle(1'b1, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
